// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - shares one memory bus port between instruction fetch and the LSU
//
// Purpose:
//   Arbitrates the fetch unit and the LSU onto a single memory bus port with at most
//   one transaction in flight. The LSU has priority. A starvation counter guarantees that fetch
//   wins after STARVE_MAX consecutive lost arbitrations. A fetch that is withdrawn while its
//   transaction is outstanding has the late response swallowed.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   if_req_i, if_addr_i           fetch read request (level) and PC
//   if_ack_o, if_rdata_o          fetch completion pulse and instruction word
//   lsu_req_i, lsu_addr_i,        LSU request (held until ack), address,
//   lsu_we_i, lsu_be_i,           write enable, byte enables,
//   lsu_wdata_i                   store data
//   lsu_ack_o, lsu_rdata_o        LSU completion pulse and load data
//   bus_req_o, bus_addr_o,        bus request (high while busy) and registered
//   bus_we_o, bus_be_o,           address, write enable, byte enables,
//   bus_wdata_o                   write data
//   bus_ack_i, bus_rdata_i        bus response strobe and read data

module imem_dmem_port_arbiter #(
   parameter int  ADDR_W     = 32,
   parameter int  DATA_W     = 32,
   parameter int  STARVE_MAX = 4,
   localparam int BE_W       = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              lsu_req_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic              lsu_we_i,
   input  logic [BE_W-1:0]   lsu_be_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_ack_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_we_o,
   output logic [BE_W-1:0]   bus_be_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSU} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   logic             drop_ff, drop_nxt;
   logic             if_win, lsu_win;
   logic             starve_full;

   assign starve_full = (starve_cnt == STARVE_LIM);
   assign bus_req_o   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         drop_ff    <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         drop_ff    <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      starve_nxt  = starve_cnt;
      drop_nxt    = drop_ff;
      if_win      = 1'b0;
      lsu_win     = 1'b0;
      if_ack_o    = 1'b0;
      if_rdata_o  = '0;
      lsu_ack_o   = 1'b0;
      lsu_rdata_o = '0;
      case (state)
         IDLE: begin
            // LSU normally wins; a starved fetch overrides it once.
            if_win  = if_req_i & (~lsu_req_i | starve_full);
            lsu_win = ~if_win & lsu_req_i;
            if (if_win) begin
               state_nxt  = BUSY_IF;
               starve_nxt = '0;
            end else if (lsu_win) begin
               state_nxt = BUSY_LSU;
               if (if_req_i && !starve_full)
                  starve_nxt = starve_cnt + CNT_W'(1);
            end
         end
         BUSY_IF: begin
            if (bus_ack_i) begin
               // A fetch killed at any point of the wait (or in the ack cycle) gets no ack.
               if (!drop_ff && if_req_i) begin
                  if_ack_o   = 1'b1;
                  if_rdata_o = bus_rdata_i;
               end
               state_nxt = IDLE;
               drop_nxt  = 1'b0;
            end else if (!if_req_i) begin
               drop_nxt = 1'b1;
            end
         end
         BUSY_LSU: begin
            if (bus_ack_i) begin
               lsu_ack_o   = 1'b1;
               lsu_rdata_o = bus_rdata_i;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus attributes are captured only at grant, so they stay frozen while busy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_addr_o  <= '0;
         bus_we_o    <= 1'b0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
      end else if (if_win) begin
         bus_addr_o  <= if_addr_i;
         bus_we_o    <= 1'b0;
         bus_be_o    <= '1;
         bus_wdata_o <= '0;
      end else if (lsu_win) begin
         bus_addr_o  <= lsu_addr_i;
         bus_we_o    <= lsu_we_i;
         bus_be_o    <= lsu_be_i;
         bus_wdata_o <= lsu_wdata_i;
      end
   end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - self-checking bench for imem_dmem_port_arbiter

module tb_imem_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        lsu_req_i;
   logic [31:0] lsu_addr_i;
   logic        lsu_we_i;
   logic [3:0]  lsu_be_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ack_o;
   logic [31:0] lsu_rdata_o;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
      .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
   );

   // Requester/bus protocol rules the stimulus must obey.
   assert property (@(posedge clk) disable iff (!rst_n) (lsu_req_i && !lsu_ack_o) |=> lsu_req_i)
      else $error("FAIL lsu_req_hold: lsu_req_i fell before lsu_ack_o");
   assert property (@(posedge clk) disable iff (!rst_n) bus_ack_i |-> bus_req_o)
      else $error("FAIL bus_ack_idle: bus_ack_i=1 while bus_req_o=0");

   typedef struct {
      logic        rst_n;
      logic        if_req;
      logic [31:0] if_addr;
      logic        lsu_req;
      logic [31:0] lsu_addr;
      logic        lsu_we;
      logic [3:0]  lsu_be;
      logic [31:0] lsu_wdata;
      logic        bus_ack;
      logic [31:0] bus_rdata;
      logic        e_if_ack;
      logic [31:0] e_if_rdata;
      logic        e_lsu_ack;
      logic [31:0] e_lsu_rdata;
      logic        e_bus_req;
      logic [31:0] e_bus_addr;
      logic        e_bus_we;
      logic [3:0]  e_bus_be;
      logic [31:0] e_bus_wdata;
   } vec_t;

   vec_t  vecs[$];
   string names[$];

   task automatic add(input string nm, input logic rs,
                      input logic ifr, input logic [31:0] ifa,
                      input logic lr, input logic [31:0] la, input logic lwe, input logic [3:0] lbe,
                      input logic [31:0] lwd, input logic ba, input logic [31:0] brd,
                      input logic eia, input logic [31:0] eird, input logic ela, input logic [31:0] elrd,
                      input logic ebr, input logic [31:0] eba, input logic ebwe, input logic [3:0] ebbe,
                      input logic [31:0] ebwd);
      vec_t v;
      v.rst_n = rs;      v.if_req = ifr;     v.if_addr = ifa;
      v.lsu_req = lr;    v.lsu_addr = la;    v.lsu_we = lwe;   v.lsu_be = lbe;  v.lsu_wdata = lwd;
      v.bus_ack = ba;    v.bus_rdata = brd;
      v.e_if_ack = eia;  v.e_if_rdata = eird; v.e_lsu_ack = ela; v.e_lsu_rdata = elrd;
      v.e_bus_req = ebr; v.e_bus_addr = eba;  v.e_bus_we = ebwe; v.e_bus_be = ebbe; v.e_bus_wdata = ebwd;
      vecs.push_back(v);
      names.push_back(nm);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] A = 32'h8000_0000;

   initial begin
      logic        found;
      logic        is_if;
      logic [31:0] prev;
      logic [31:0] rd;

      rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0; lsu_req_i = 1'b0; lsu_addr_i = '0;
      lsu_we_i = 1'b0; lsu_be_i = '0; lsu_wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;

      // name, rst | if_req if_addr | lsu_req addr we be wdata | bus_ack rdata ||
      //   exp if_ack if_rdata lsu_ack lsu_rdata | bus_req addr we be wdata
      add("rst_idle",  1, 0, 0,  0, 0, 0, 0, 0,  0, 0,            0, 0, 0, 0,  0, 0, 0, 0, 0);
      // T1 single fetch, ack two cycles after bus_req
      add("t1_grant",  1, 1, A,  0, 0, 0, 0, 0,  0, 0,            0, 0, 0, 0,  0, 0, 0, 0, 0);
      add("t1_wait1",  1, 1, A,  0, 0, 0, 0, 0,  0, 0,            0, 0, 0, 0,  1, A, 0, 4'hF, 0);
      add("t1_wait2",  1, 1, A,  0, 0, 0, 0, 0,  0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, A, 0, 4'hF, 0);
      add("t1_ack",    1, 1, A,  0, 0, 0, 0, 0,  1, 32'h13,       1, 32'h13, 0, 0, 1, A, 0, 4'hF, 0);
      add("t1_idle",   1, 0, 0,  0, 0, 0, 0, 0,  0, 0,            0, 0, 0, 0,  0, A, 0, 4'hF, 0);
      // T2 simultaneous requests: LSU first, then fetch
      add("t2_grant",  1, 1, 32'h500, 1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, A, 0, 4'hF, 0);
      add("t2_lsu_ack",1, 1, 32'h500, 1, 32'h100, 0, 4'hF, 0, 1, 32'h1234_5678,
          0, 0, 1, 32'h1234_5678, 1, 32'h100, 0, 4'hF, 0);
      add("t2_if_grant",1, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 32'h100, 0, 4'hF, 0);
      add("t2_if_ack", 1, 1, 32'h500, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001,
          1, 32'hAAAA_0001, 0, 0, 1, 32'h500, 0, 4'hF, 0);
      // T3 continuous contention, single-cycle ack: LSU x4, IF, LSU
      for (int k = 0; k < 6; k++) begin
         is_if = (k == 4);
         prev  = (k == 0) ? 32'h500 : ((k == 5) ? 32'h600 : 32'h104);
         rd    = 32'h31 + k;
         add($sformatf("t3_idle%0d", k), 1, 1, 32'h600, 1, 32'h104, 0, 4'hF, 0, 0, 0,
             0, 0, 0, 0, 0, prev, 0, 4'hF, 0);
         add($sformatf("t3_ack%0d", k), 1, 1, 32'h600, 1, 32'h104, 0, 4'hF, 0, 1, rd,
             is_if, is_if ? rd : 32'h0, !is_if, is_if ? 32'h0 : rd,
             1, is_if ? 32'h600 : 32'h104, 0, 4'hF, 0);
      end
      // T4 fetch killed for one cycle, late ack discarded, then a clean refetch
      add("t4_grant",  1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 32'h104, 0, 4'hF, 0);
      add("t4_kill",   1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 32'h200, 0, 4'hF, 0);
      add("t4_wait1",  1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 32'h200, 0, 4'hF, 0);
      add("t4_wait2",  1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 32'h200, 0, 4'hF, 0);
      add("t4_late",   1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hBAD0, 0, 0, 0, 0, 1, 32'h200, 0, 4'hF, 0);
      add("t4_regrant",1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 32'h200, 0, 4'hF, 0);
      add("t4_ack",    1, 1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0300_0013,
          1, 32'h0300_0013, 0, 0, 1, 32'h300, 0, 4'hF, 0);
      // T5 store with wdata changing while waiting
      add("t5_grant",  1, 0, 0, 1, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF, 0, 0,
          0, 0, 0, 0, 0, 32'h300, 0, 4'hF, 0);
      add("t5_hold1",  1, 0, 0, 1, 32'h400, 1, 4'b0011, 32'h1111_1111, 0, 0,
          0, 0, 0, 0, 1, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF);
      add("t5_hold2",  1, 0, 0, 1, 32'h400, 1, 4'b0011, 32'h2222_2222, 0, 0,
          0, 0, 0, 0, 1, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF);
      add("t5_ack",    1, 0, 0, 1, 32'h400, 1, 4'b0011, 32'h3333_3333, 1, 0,
          0, 0, 1, 0, 1, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF);
      add("t5_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          0, 0, 0, 0, 0, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF);
      // T6 reset while BUSY_LSU (fetch also waiting, so starve_cnt is nonzero)
      add("t6_grant",  1, 1, 32'h800, 1, 32'h700, 0, 4'hF, 0, 0, 0,
          0, 0, 0, 0, 0, 32'h400, 1, 4'b0011, 32'hDEAD_BEEF);
      add("t6_rst",    0, 1, 32'h800, 1, 32'h700, 0, 4'hF, 0, 0, 0,
          0, 0, 0, 0, 1, 32'h700, 0, 4'hF, 0);
      add("t6_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n;   if_req_i = vecs[i].if_req;   if_addr_i = vecs[i].if_addr;
         lsu_req_i = vecs[i].lsu_req; lsu_addr_i = vecs[i].lsu_addr; lsu_we_i = vecs[i].lsu_we;
         lsu_be_i = vecs[i].lsu_be; lsu_wdata_i = vecs[i].lsu_wdata;
         bus_ack_i = vecs[i].bus_ack; bus_rdata_i = vecs[i].bus_rdata;
         #1;
         chk({names[i], ".if_ack"},    32'(if_ack_o),    32'(vecs[i].e_if_ack));
         chk({names[i], ".if_rdata"},  if_rdata_o,        vecs[i].e_if_rdata);
         chk({names[i], ".lsu_ack"},   32'(lsu_ack_o),   32'(vecs[i].e_lsu_ack));
         chk({names[i], ".lsu_rdata"}, lsu_rdata_o,       vecs[i].e_lsu_rdata);
         chk({names[i], ".bus_req"},   32'(bus_req_o),   32'(vecs[i].e_bus_req));
         chk({names[i], ".bus_addr"},  bus_addr_o,        vecs[i].e_bus_addr);
         chk({names[i], ".bus_we"},    32'(bus_we_o),    32'(vecs[i].e_bus_we));
         chk({names[i], ".bus_be"},    32'(bus_be_o),    32'(vecs[i].e_bus_be));
         chk({names[i], ".bus_wdata"}, bus_wdata_o,       vecs[i].e_bus_wdata);
      end

      // After the reset, starvation must count from zero again: expect LSU x4, IF, LSU.
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h800;
      lsu_req_i = 1'b1; lsu_addr_i = 32'h900; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_wdata_i = '0;
      bus_ack_i = 1'b0; bus_rdata_i = '0;
      for (int g = 0; g < 6; g++) begin
         found = 1'b0;
         for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            #1;
            if (bus_req_o) found = 1'b1;
         end
         if (!found) begin
            chk($sformatf("post_rst_grant%0d_timeout", g), 32'(bus_req_o), 32'd1);
            break;
         end
         is_if = (bus_addr_o == 32'h800);
         chk($sformatf("post_rst_grant%0d_is_if", g), 32'(is_if), 32'(g == 4));
         bus_ack_i = 1'b1; bus_rdata_i = 32'h40 + g;
         #1;
         chk($sformatf("post_rst_ack%0d_if", g),  32'(if_ack_o),  32'(g == 4));
         chk($sformatf("post_rst_ack%0d_lsu", g), 32'(lsu_ack_o), 32'(g != 4));
      end
      @(negedge clk);
      bus_ack_i = 1'b0; if_req_i = 1'b0; lsu_req_i = 1'b0;
      #1;
      chk("post_rst_final_idle", 32'(bus_req_o), 32'd0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
